// File: rtl/seg7_scan_decoder_pkg.sv
// rtl/seg7_scan_decoder_pkg.sv - shared glyph table, defaults and FSM state type
// Used by both the hex encoder and the scan decoder, so the two always agree on glyphs.
package seg7_scan_decoder_pkg;

  localparam int         NUM_DIGITS_DEFAULT = 4;
  localparam logic [6:0] SEG_BLANK          = 7'h7F;

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_HOLD    = 1'b1
  } scan_state_e;

  // Active-low {g,f,e,d,c,b,a} glyph for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      4'hF: return 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// rtl/seg7_scan_decoder_if.sv - scanned display bus and decoded frame outputs
// seg/dig_en: scanned display bus in; val/val_valid/digit_err: decoded frame out.
// master = display/bench side, slave = decoder side.
interface seg7_scan_decoder_if
  import seg7_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
);

  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic [4*NUM_DIGITS-1:0] val;
  logic                    val_valid;
  logic [NUM_DIGITS-1:0]   digit_err;

  modport master (
    output seg,
    output dig_en,
    input  val,
    input  val_valid,
    input  digit_err
  );

  modport slave (
    input  seg,
    input  dig_en,
    output val,
    output val_valid,
    output digit_err
  );

endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational active-low glyph to nibble lookup
// seg_i: pattern in; nibble_o: decoded value (0 when unknown); valid_o: pattern is a hex glyph.
module seg7_decode
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       valid_o
);

  // Inverting the encoder's own table keeps encode/decode exact inverses.
  always_comb begin
    nibble_o = '0;
    valid_o  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == hex_to_seg(4'(i))) begin
        nibble_o = 4'(i);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - debounced capture of a multiplexed 7-segment bus into hex frames
// clk/rst: clock and async active-high reset; bus: slave side of seg7_scan_decoder_if
// (seg, dig_en in; val, val_valid, digit_err out).
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS    = NUM_DIGITS_DEFAULT,
  parameter int STABLE_CYCLES = 8
) (
  input logic                clk,
  input logic                rst,
  seg7_scan_decoder_if.slave bus
);

  localparam int             CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
  // The counter holds the number of qualified comparisons, which is one less
  // than the number of identical samples; capture when this sample makes it
  // STABLE_CYCLES identical samples.
  localparam logic [CW-1:0]  CAP_AT  = CW'(STABLE_CYCLES - 2);

  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  scan_state_e             state_q, state_d;
  logic [4*NUM_DIGITS-1:0] slot_nib_q, slot_nib_d;
  logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    val_valid_q, val_valid_d;

  logic       qual;
  logic       cap;
  logic       frame_done;
  logic [3:0] dec_nib;
  logic       dec_valid;

  seg7_decode u_decode (
    .seg_i    (bus.seg),
    .nibble_o (dec_nib),
    .valid_o  (dec_valid)
  );

  assign qual       = $onehot(bus.dig_en) && (bus.seg == seg_q) && (bus.dig_en == en_q);
  assign frame_done = &mask_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    if (!qual) begin
      cnt_d   = '0;
      state_d = ST_ACQUIRE;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      if (state_q == ST_ACQUIRE && cnt_q == CAP_AT) begin
        cap     = 1'b1;
        state_d = ST_HOLD;
      end
    end
  end

  always_comb begin
    slot_nib_d = slot_nib_q;
    slot_err_d = slot_err_q;
    if (cap) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bus.dig_en[i]) begin
          slot_nib_d[4*i +: 4] = dec_nib;
          slot_err_d[i]        = ~dec_valid;
        end
      end
    end
    // A capture landing on the frame-load edge seeds the next frame's mask.
    mask_d      = (frame_done ? '0 : mask_q) | (cap ? bus.dig_en : '0);
    val_d       = frame_done ? slot_nib_q : val_q;
    err_d       = frame_done ? slot_err_q : err_q;
    val_valid_d = frame_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q       <= SEG_BLANK;
      en_q        <= '0;
      cnt_q       <= '0;
      state_q     <= ST_ACQUIRE;
      slot_nib_q  <= '0;
      slot_err_q  <= '0;
      mask_q      <= '0;
      val_q       <= '0;
      err_q       <= '0;
      val_valid_q <= 1'b0;
    end else begin
      seg_q       <= bus.seg;
      en_q        <= bus.dig_en;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      slot_nib_q  <= slot_nib_d;
      slot_err_q  <= slot_err_d;
      mask_q      <= mask_d;
      val_q       <= val_d;
      err_q       <= err_d;
      val_valid_q <= val_valid_d;
    end
  end

  assign bus.val       = val_q;
  assign bus.val_valid = val_valid_q;
  assign bus.digit_err = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

  localparam int ND     = 4;
  localparam int STABLE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Independent glyph table (active-low gfedcba).
  logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_assert = 0;
  int n_fail   = 0;
  int n_pulse  = 0;

  // Reference model state: length of the current run of identical one-hot
  // samples, whether this dwell was already taken, and per-digit slots.
  logic [6:0]      m_prev_seg;
  logic [ND-1:0]   m_prev_en;
  int              m_run;
  bit              m_taken;
  logic [3:0]      m_nib [ND];
  logic            m_err [ND];
  logic [ND-1:0]   m_mask;
  logic [4*ND-1:0] exp_val;
  logic [ND-1:0]   exp_err;
  logic            exp_vv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_seg = 7'h7F;
    m_prev_en  = '0;
    m_run      = 0;
    m_taken    = 1'b0;
    m_mask     = '0;
    exp_val    = '0;
    exp_err    = '0;
    exp_vv     = 1'b0;
    for (int i = 0; i < ND; i++) begin
      m_nib[i] = 4'h0;
      m_err[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [6:0]    s;
    logic [ND-1:0] e;
    bit            q;
    int            idx;
    s = bus.seg;
    e = bus.dig_en;
    q = $onehot(e) && (s == m_prev_seg) && (e == m_prev_en);
    if (q) m_run++;
    else begin
      m_run   = 1;
      m_taken = 1'b0;
    end
    exp_vv = (m_mask == '1);
    if (exp_vv) begin
      for (int i = 0; i < ND; i++) begin
        exp_val[4*i +: 4] = m_nib[i];
        exp_err[i]        = m_err[i];
      end
      m_mask = '0;
    end
    if (q && m_run == STABLE && !m_taken) begin
      m_taken = 1'b1;
      idx = 0;
      for (int i = 0; i < ND; i++) if (e[i]) idx = i;
      m_nib[idx] = 4'h0;
      m_err[idx] = 1'b1;
      for (int k = 0; k < 16; k++) begin
        if (gl[k] == s) begin
          m_nib[idx] = 4'(k);
          m_err[idx] = 1'b0;
        end
      end
      m_mask[idx] = 1'b1;
    end
    m_prev_seg = s;
    m_prev_en  = e;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (bus.val_valid === 1'b1) n_pulse++;
    chk("val", 32'(bus.val), 32'(exp_val));
    chk("val_valid", 32'(bus.val_valid), 32'(exp_vv));
    chk("digit_err", 32'(bus.digit_err), 32'(exp_err));
  endtask

  task automatic drive(input logic [ND-1:0] en, input logic [6:0] s, input int n);
    bus.dig_en = en;
    bus.seg    = s;
    repeat (n) cyc();
  endtask

  task automatic drive_digit(input int d, input logic [6:0] s, input int n);
    drive(ND'(1) << d, s, n);
  endtask

  // Entered at a falling edge; reset takes effect without waiting for a clock.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_val"}, 32'(bus.val), 32'h0);
    chk({tag, "_vv"}, 32'(bus.val_valid), 32'h0);
    chk({tag, "_err"}, 32'(bus.digit_err), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    bus.seg    = 7'h7F;
    bus.dig_en = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_val", 32'(bus.val), 32'h0);
    chk("rst_vv", 32'(bus.val_valid), 32'h0);
    chk("rst_err", 32'(bus.digit_err), 32'h0);
    rst = 1'b0;

    // Every glyph on digit 0 across a complete frame.
    for (int g = 0; g < 16; g++) begin
      drive_digit(3, gl[3], 10);
      drive_digit(2, gl[2], 10);
      drive_digit(1, gl[1], 10);
      drive_digit(0, gl[g], 10);
      chk("glyph_val", 32'(bus.val), 32'h3210 | 32'(g));
      chk("glyph_err0", 32'(bus.digit_err[0]), 32'h0);
    end

    // 1-2-A-F frame with the pulse position checked.
    do_reset("rst27");
    p0 = n_pulse;
    drive_digit(3, 7'b1111001, 10);
    drive_digit(2, 7'b0100100, 10);
    drive_digit(1, 7'b0001000, 10);
    drive_digit(0, 7'b0001110, 8);
    chk("f27_no_early", 32'(bus.val_valid), 32'h0);
    cyc();
    chk("f27_pulse", 32'(bus.val_valid), 32'h1);
    chk("f27_val", 32'(bus.val), 32'h12AF);
    chk("f27_err", 32'(bus.digit_err), 32'h0);
    cyc();
    chk("f27_pulse_end", 32'(bus.val_valid), 32'h0);
    chk("f27_count", 32'(n_pulse - p0), 32'h1);

    // Short glitch on digit 2 must not be captured.
    drive_digit(3, gl[3], 10);
    drive_digit(2, gl[2], 10);
    drive_digit(2, 7'b0000000, 5);
    drive_digit(1, gl[1], 10);
    drive_digit(0, gl[0], 10);
    chk("glitch_val", 32'(bus.val), 32'h3210);

    // Blank on digit 0.
    drive_digit(3, gl[1], 10);
    drive_digit(2, gl[2], 10);
    drive_digit(1, gl[3], 10);
    drive_digit(0, 7'h7F, 10);
    chk("blank_err", 32'(bus.digit_err), 32'h1);
    chk("blank_nib", 32'(bus.val[3:0]), 32'h0);

    // Reset mid-frame discards the partial frame.
    drive_digit(3, gl[4], 10);
    drive_digit(2, gl[5], 10);
    do_reset("rst30");
    p0 = n_pulse;
    drive_digit(1, gl[6], 10);
    drive_digit(0, gl[7], 10);
    chk("partial_no_pulse", 32'(n_pulse - p0), 32'h0);
    drive_digit(3, gl[4], 10);
    drive_digit(2, gl[5], 10);
    drive_digit(1, gl[6], 10);
    drive_digit(0, gl[7], 10);
    chk("recapture_pulse", 32'(n_pulse - p0), 32'h1);
    chk("recapture_val", 32'(bus.val), 32'h4567);

    // Multi-hot and zero strobes never capture.
    do_reset("rst31");
    p0 = n_pulse;
    drive_digit(3, gl[9], 10);
    drive_digit(2, gl[9], 10);
    drive_digit(1, gl[9], 10);
    drive(4'b0011, gl[9], 20);
    drive(4'b0000, gl[9], 20);
    chk("strobe_no_pulse", 32'(n_pulse - p0), 32'h0);

    // Random dwells against the model.
    for (int r = 0; r < 400; r++) begin
      logic [ND-1:0] en;
      logic [6:0]    s;
      if ($urandom_range(0, 9) == 0) en = ND'($urandom_range(0, 15));
      else                           en = ND'(1) << $urandom_range(0, ND - 1);
      if ($urandom_range(0, 4) == 0) s = 7'($urandom_range(0, 127));
      else                           s = gl[$urandom_range(0, 15)];
      drive(en, s, $urandom_range(1, 14));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
